// File: rtl/iir_voice_sequencer.sv
// Time-multiplexes one stateless 1-pole IIR math stage across NUM_VOICES voices.
// Owns the per-voice feedback bank and sequences fetch/load/calc per sample strobe.
module iir_voice_sequencer #(
  parameter int unsigned NUM_VOICES = 8,
  parameter int unsigned VIDX_W     = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sample_strobe,
  input  logic                     clear_state,
  output logic                     rd_en,
  output logic [VIDX_W-1:0]        rd_idx,
  input  logic signed [17:0]       in_sample,
  input  logic signed [35:0]       del_in,
  output logic signed [17:0]       iir_i,
  output logic signed [35:0]       iir_del,
  output logic signed [17:0]       iir_fb,
  input  logic signed [17:0]       iir_o,
  output logic signed [17:0]       out_sample,
  output logic [VIDX_W-1:0]        out_voice,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_CALC} state_t;

  localparam logic [VIDX_W-1:0] LAST_V = VIDX_W'(NUM_VOICES - 1);

  state_t                   r_state;
  logic [VIDX_W-1:0]        r_v;
  logic                     r_pending;
  logic signed [17:0]       r_fb [NUM_VOICES];
  logic signed [35:0]       w_del_clamped;

  // Negative DEL is meaningless to the filter; pin it to zero.
  assign w_del_clamped = del_in[35] ? '0 : del_in;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_v        <= '0;
      r_pending  <= 1'b0;
      rd_en      <= 1'b0;
      rd_idx     <= '0;
      iir_i      <= '0;
      iir_del    <= '0;
      iir_fb     <= '0;
      out_sample <= '0;
      out_voice  <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) r_fb[i] <= '0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Clear lands before a coincident strobe's first LOAD, so FB reads zero.
          if (clear_state || r_pending) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) r_fb[i] <= '0;
            r_pending <= 1'b0;
            overrun   <= 1'b0;
          end
          if (sample_strobe) begin
            r_v     <= '0;
            rd_en   <= 1'b1;
            rd_idx  <= '0;
            busy    <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_en   <= 1'b0;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          iir_i   <= in_sample;
          iir_del <= w_del_clamped;
          iir_fb  <= r_fb[r_v];
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_fb[r_v]  <= iir_o;
          out_sample <= iir_o;
          out_voice  <= r_v;
          out_valid  <= 1'b1;
          if (r_v == LAST_V) begin
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_v     <= r_v + VIDX_W'(1);
            rd_en   <= 1'b1;
            rd_idx  <= r_v + VIDX_W'(1);
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (r_state != S_IDLE) begin
        if (sample_strobe) overrun   <= 1'b1;
        if (clear_state)   r_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/iir_voice_sequencer.md
Name: iir_voice_sequencer

Overview:
- Time-multiplexes one combinational 1-pole IIR filter-math stage across NUM_VOICES synth voices.
- On each audio sample strobe it walks the voices in order. For each voice it:
  - fetches the voice's input sample and DEL from upstream (the per-voice sample source and the pipelined cuber);
  - presents I/DEL/FB to the filter math;
  - captures O back into a per-voice feedback bank and emits it downstream.
- The filter math holds no state. This block owns all filter state.

Parameters:
- NUM_VOICES, 8, number of voices serviced per sample strobe (2..64).
- VIDX_W, 3, voice index width; must satisfy 2**VIDX_W >= NUM_VOICES.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- sample_strobe  in  1  one-cycle pulse, start of an audio sample period.
- clear_state  in  1  request to zero all feedback registers.
- rd_en  out  1  upstream read request for voice rd_idx.
- rd_idx  out  VIDX_W  voice being fetched.
- in_sample  in  18  signed voice input; valid the cycle after rd_en.
- del_in  in  36  signed DEL from cuber; valid the cycle after rd_en.
- iir_i  out  18  signed, to filter I.
- iir_del  out  36  signed, to filter DEL.
- iir_fb  out  18  signed, to filter FB.
- iir_o  in  18  signed filter O; combinational from iir_i/iir_del/iir_fb.
- out_sample  out  18  signed filtered sample.
- out_voice  out  VIDX_W  voice index of out_sample.
- out_valid  out  1  one-cycle qualifier for out_sample/out_voice.
- busy  out  1  high while servicing voices.
- overrun  out  1  sticky: a strobe arrived while busy.

Behaviour:
- Reset (reset_n=0 at clock edge), which also aborts any in-progress sequence immediately:
  - FSM goes to IDLE.
  - All outputs are 0: rd_en, rd_idx, iir_*, out_*, busy, overrun.
  - All NUM_VOICES feedback registers are 0.
  - Pending clear is 0.
- FSM states:
  - IDLE: busy=0. On sample_strobe, v<=0 and go to FETCH.
  - FETCH: rd_en=1, rd_idx=v. Go to LOAD.
  - LOAD:
    - iir_i<=in_sample.
    - iir_del<=clamp(del_in).
    - iir_fb<=fb_bank[v].
    - Go to CALC.
  - CALC: iir_o settles combinationally. At the edge leaving CALC:
    - fb_bank[v]<=iir_o, out_sample<=iir_o, out_voice<=v, out_valid<=1 for exactly one cycle.
    - If v==NUM_VOICES-1, go to IDLE; else v<=v+1 and go to FETCH.
- busy=1 in FETCH, LOAD and CALC. rd_en=0 outside FETCH. rd_idx holds its last value when rd_en=0.
- Timing: strobe sampled in cycle T.
  - Voice k: FETCH at T+1+3k, LOAD at T+2+3k, CALC at T+3+3k, out_valid at T+4+3k.
  - Sequence length 3*NUM_VOICES cycles. IDLE is re-entered at T+1+3*NUM_VOICES.
- DEL clamp: if del_in is negative, iir_del=0; else iir_del=del_in. Valid range is 0..36'h7FFFFFFFF.
- iir_i, iir_del and iir_fb are held stable from LOAD through CALC; they change only in LOAD.
- sample_strobe while busy:
  - ignored; no restart, no change to v;
  - overrun<=1 and remains set until reset or until a clear is applied.
- clear_state:
  - Sampled every cycle. If busy, it sets a pending flag.
  - The clear is applied on any IDLE cycle where clear_state or pending is high: all fb_bank<=0, pending<=0, overrun<=0.
  - If sample_strobe coincides with an applied clear in IDLE: the clear takes effect, and the new sequence starts with FB=0 for every voice.
- Strobe arriving in the same cycle the FSM re-enters IDLE: accepted normally (no overrun).
- No arithmetic on samples is done here. out_sample is iir_o bit-exact.

Test Plan:
- Reset then single strobe, NUM_VOICES=8, all voices in_sample=18'sh10000, del_in=0:
  - out_valid pulses at T+4, T+7, ... T+25;
  - out_voice=0..7 in order; out_sample=18'sh0FFFF for each.
- del_in=36'h7FFFFFFFF, fb=0, in_sample=18'sh1FFFF:
  - iir_del=36'h7FFFFFFFF; out_sample=0.
  - Second strobe still yields 0 (pure hold of FB=0).
- del_in=36'hFFFFFFFFF (-1), in_sample=18'sh10000:
  - iir_del observed 0 in LOAD/CALC; out_sample=18'sh0FFFF.
- Strobe at T, second strobe at T+5:
  - overrun=1 from T+6; sequence completes unchanged at T+25.
  - clear_state pulsed at T+10: pending until IDLE, then all fb=0 and overrun=0.
- Drive del_in=36'h400000000, in_sample=18'sh10000 for several strobes:
  - per-voice out_sample trajectories match a golden model of O=((I*a0+FB*b1)<<1)>>>18 with a0/b1 derived from DEL;
  - fb of voice k is never disturbed by voice j.
- reset_n low during LOAD of voice 3:
  - next cycle all outputs 0, busy=0;
  - following strobe restarts at voice 0 with FB=0.
